// File: rtl/avm_burst_read_master.sv
// rtl/avm_burst_read_master.sv - Avalon-MM burst read initiator with credit-limited output FIFO
// Optional read watchdog enabled by defining AVM_TIMEOUT_EN.
module avm_burst_read_master #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_busy,
    output logic              cmd_done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(DATA_W / 8);
    localparam logic [SUM_W-1:0]  CREDITS = SUM_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              read_q, read_d;
    logic              busy_q, done_q;
    logic [DATA_W-1:0] mem_q [MAX_OUTSTANDING];
    logic              accept, active, push, pop;
`ifdef AVM_TIMEOUT_EN
    logic              err_q, err_d;
    logic [15:0]       wdog_q, wdog_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        accept     = read_q && !avm_waitrequest;
        active     = (state_q == S_RUN) || (state_q == S_DRAIN);
        push       = avm_readdatavalid && active;
        pop        = (count_q != '0) && out_ready;
        state_d    = state_q;
        addr_d     = accept ? addr_q + STRIDE : addr_q;
        len_d      = len_q;
        issued_d   = accept ? issued_q + 1'b1 : issued_q;
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    issued_d = '0;
                    state_d  = (cmd_len == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN:   if (issued_d == len_q) state_d = S_DRAIN;
            S_DRAIN: if (inflight_q == '0 && count_q == '0) state_d = S_FINISH;
            default: state_d = S_IDLE;
        endcase
`ifdef AVM_TIMEOUT_EN
        err_d  = err_q;
        wdog_d = (active && inflight_q != '0 && !avm_readdatavalid) ? wdog_q + 1'b1 : '0;
        if (active && wdog_q == 16'hFFFF) begin
            err_d      = 1'b1;
            state_d    = S_FINISH;
            inflight_d = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            wdog_d     = '0;
        end
`endif
        // During a stall credits can only grow, so a pending read is never withdrawn here.
        read_d = (state_d == S_RUN) && (issued_d < len_d) &&
                 ((SUM_W'(inflight_d) + SUM_W'(count_d)) < CREDITS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef AVM_TIMEOUT_EN
            err_q      <= 1'b0;
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            read_q     <= read_d;
            busy_q     <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q     <= (state_q == S_FINISH);
`ifdef AVM_TIMEOUT_EN
            err_q      <= err_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= avm_readdata;
    end

    assign cmd_busy    = busy_q;
    assign cmd_done    = done_q;
    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
`ifdef AVM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_avm_burst_read_master.sv
// tb/tb_avm_burst_read_master.sv - table-driven bench for avm_burst_read_master
module tb_avm_burst_read_master;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset, cmd_start, cmd_busy, cmd_done;
    logic [31:0] cmd_addr, avm_address, avm_readdata, out_data;
    logic [15:0] cmd_len;
    logic        avm_read, avm_waitrequest, avm_readdatavalid;
    logic        out_valid, out_ready, err;

    always #5 clk = ~clk;

    avm_burst_read_master #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        int          stall_idx;
        int          stall_len;
        int          ready_off;
        bit          poke;
        int          exp_hold;
    } vec_t;

    vec_t        tbl[5];
    int          total = 0, bad = 0, cyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] base, prev_addr;
    int          acc_cnt, pop_cnt, ret_cnt, done_cnt, done_busy_bad, addr_bad, over;
    int          stall_idx, stall_left, ready_off_left;
    bit          prev_stall, prev_rdv;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic init_model(input logic [31:0] b, input int sidx, input int slen, input int roff);
        base = b; stall_idx = sidx; stall_left = slen; ready_off_left = roff;
        acc_cnt = 0; pop_cnt = 0; ret_cnt = 0; done_cnt = 0;
        done_busy_bad = 0; addr_bad = 0; over = 0;
        prev_stall = 0; prev_rdv = 0;
        pend_addr.delete(); pend_due.delete();
    endtask

    // One clock: drive slave/sink inputs, observe the cycle, advance past the edge.
    task automatic step();
        logic [31:0] a;
        int          d;
        avm_readdatavalid = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            a = pend_addr.pop_front();
            d = pend_due.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata = word_of(a);
        end
        avm_waitrequest = 1'b0;
        if (avm_read && acc_cnt == stall_idx && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end
        out_ready = (ready_off_left == 0);
        if (ready_off_left > 0) ready_off_left--;
        #1;
        if (prev_stall) check("stall_hold", {avm_read, avm_address}, {1'b1, prev_addr});
        if (prev_rdv) check("valid_after_rdv", out_valid, 1);
        if (avm_readdatavalid && ret_cnt == pop_cnt) check("no_forward", out_valid, 0);
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        prev_rdv   = avm_readdatavalid;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address !== base + 32'(acc_cnt * 4)) addr_bad++;
            pend_addr.push_back(avm_address);
            pend_due.push_back(cyc + 2);
            acc_cnt++;
        end
        if (avm_readdatavalid) ret_cnt++;
        if (out_valid && out_ready) begin
            check("stream_data", out_data, word_of(base + 32'(pop_cnt * 4)));
            pop_cnt++;
        end
        if (acc_cnt - pop_cnt > MAXO) over++;
        if (cmd_done) begin
            done_cnt++;
            if (cmd_busy) done_busy_bad++;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_burst(input vec_t v);
        int n;
        init_model(v.addr, v.stall_idx, v.stall_len, v.ready_off);
        cmd_addr = v.addr; cmd_len = v.len; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check("start_busy", cmd_busy, 1);
        check("first_read", {avm_read, avm_address}, {1'b1, v.addr});
        if (v.poke) begin
            cmd_addr = 32'h9000; cmd_len = 16'd5; cmd_start = 1'b1;
            step();
            cmd_start = 1'b0;
        end
        while (ready_off_left > 0) step();
        if (v.exp_hold > 0) begin
            check("credit_reads", acc_cnt, v.exp_hold);
            check("credit_read_low", avm_read, 0);
        end
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            step();
            n++;
        end
        for (int i = 0; i < 3; i++) step();
        check("done_pulses", done_cnt, 1);
        check("done_busy", done_busy_bad, 0);
        check("reads", acc_cnt, v.len);
        check("delivered", pop_cnt, v.len);
        check("addr_seq", addr_bad, 0);
        check("overflow", over, 0);
        check("idle_after", {cmd_busy, avm_read, out_valid}, 0);
    endtask

    initial begin
        tbl[0] = '{32'h0000_1000, 16'd4,  -1, 0, 0,  1'b0, 0};
        tbl[1] = '{32'h0000_1000, 16'd8,   1, 3, 0,  1'b0, 0};
        tbl[2] = '{32'h0000_2000, 16'd10, -1, 0, 20, 1'b0, 4};
        tbl[3] = '{32'hFFFF_FFF8, 16'd3,  -1, 0, 0,  1'b0, 0};
        tbl[4] = '{32'h0000_3000, 16'd3,  -1, 0, 0,  1'b1, 0};

        reset = 1'b1; cmd_start = 1'b0; cmd_addr = '0; cmd_len = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; out_ready = 1'b1;
        init_model(32'h0, -1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", cmd_busy, 0);
        check("rst_done", cmd_done, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 5; r++) run_burst(tbl[r]);

        // Zero-length command: no bus traffic, done two cycles after the strobe.
        init_model(32'h7000, -1, 0, 0);
        cmd_addr = 32'h7000; cmd_len = 16'd0; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check("len0_c1", {cmd_busy, cmd_done, avm_read}, 0);
        step();
        check("len0_c2_done", {cmd_busy, cmd_done}, 2'b01);
        step();
        check("len0_c3", cmd_done, 0);
        check("len0_reads", acc_cnt, 0);

        // Reset after two accepted reads, then stale data arrives.
        init_model(32'h5000, -1, 0, 0);
        cmd_addr = 32'h5000; cmd_len = 16'd6; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        step();
        step();
        check("abort_accepts", acc_cnt, 2);
        reset = 1'b1; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_rst_ctl", {cmd_busy, cmd_done, avm_read, out_valid, err}, 0);
        check("abort_rst_addr", avm_address, 0);
        check("abort_rst_data", out_data, 0);
        avm_readdatavalid = 1'b1; avm_readdata = word_of(32'h5000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("stale_no_push", out_valid, 0);
            check("stale_no_done", cmd_done, 0);
        end
        avm_readdatavalid = 1'b0;
        @(posedge clk); #1;
        run_burst(tbl[0]);

`ifdef AVM_TIMEOUT_EN
        begin
            int n;
            n = 0;
            avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; out_ready = 1'b1;
            cmd_addr = 32'h6000; cmd_len = 16'd2; cmd_start = 1'b1;
            @(posedge clk); #1;
            cmd_start = 1'b0;
            while (!cmd_done && n < 70000) begin
                @(posedge clk); #1;
                n++;
            end
            check("timeout_done", cmd_done, 1);
            check("timeout_err", err, 1);
            check("timeout_late", n > 65000, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avm_burst_read_master.md
Name: avm_burst_read_master

Overview:
- Avalon-MM read initiator: the FPGA-side counterpart to the HPS-facing PIO slaves in Computer_System.
- On a command it issues CMD_LEN sequential single-word pipelined reads from a base byte address on an Avalon-MM bus, and honours waitrequest/readdatavalid.
- Returned words go out on a valid/ready stream through an internal credit-limited FIFO.
- Used to pull pixel/card data from on-chip memory into the VGA/M10k datapath.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- DATA_W, 32, read data width; must be a power of two and at least 8.
- MAX_OUTSTANDING, 4, FIFO depth and the maximum number of reads in flight plus buffered words; power of two.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle command strobe.
- cmd_addr  in  ADDR_W  base byte address, DATA_W/8 aligned.
- cmd_len  in  LEN_W  number of words to read.
- cmd_busy  out  1  high while a command is active.
- cmd_done  out  1  one-cycle pulse at command completion.
- avm_address  out  ADDR_W  read address.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  returned data.
- avm_readdatavalid  in  1  returned-data strobe.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- err  out  1  sticky timeout flag; constant 0 unless AVM_TIMEOUT_EN is defined.

Behaviour:
- Reset values: cmd_busy=0, cmd_done=0, avm_read=0, avm_address=0, out_valid=0, out_data=0, err=0.
- Reset flushes the FIFO, clears all counters and returns the FSM to IDLE.
- Reset mid-command aborts it; no cmd_done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE: cmd_start latches addr and len.
  - len=0: go to FINISH. No bus activity occurs.
  - len>0: go to RUN; cmd_busy=1 from the next cycle.
- cmd_start outside IDLE is ignored.
- RUN, issue rule: avm_read=1 when issued<len and (inflight + fifo_count) < MAX_OUTSTANDING.
- RUN, stall rule: while avm_waitrequest=1, avm_read and avm_address hold stable. Deasserting avm_read during a stall is forbidden.
- RUN, acceptance: a read is accepted on a cycle where avm_read=1 and avm_waitrequest=0. Acceptance increments issued and inflight and advances avm_address by DATA_W/8.
- RUN, throughput: back-to-back accepted reads are allowed, one per cycle.
- RUN, exit: when issued==len, go to DRAIN.
- Read data: each avm_readdatavalid pushes avm_readdata into the FIFO and decrements inflight.
  - The credit rule guarantees the FIFO never overflows; no back-pressure to the slave is needed.
  - An accept and a return in the same cycle leave inflight unchanged.
- In IDLE, avm_readdatavalid is ignored: stale data after a reset is discarded.
- Stream:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A pop occurs on out_valid && out_ready.
  - A simultaneous push and pop is legal in every state, including when the FIFO is full (pop frees the slot) and when it is empty (data is not forwarded combinationally, so latency is ≥1 cycle).
- DRAIN: wait until inflight==0 and the FIFO is empty and the final pop has occurred; then go to FINISH.
- FINISH: cmd_done=1 for exactly one cycle and cmd_busy=0 in that cycle. The next state is IDLE, and a new cmd_start is accepted from that IDLE cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Counters are LEN_W bits; cmd_len maximum is 2^LEN_W-1.
- Latency: the first avm_read asserts 1 cycle after cmd_start is accepted. Data reaches out_valid 1 cycle after its avm_readdatavalid.

Optional Feature:
- AVM_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles in RUN/DRAIN with inflight>0 and no avm_readdatavalid.
  - It resets to 0 on each return or on leaving the active states.
  - At 65535: err=1 (sticky until reset), FIFO flushed, inflight cleared, avm_read dropped, go to FINISH; cmd_done still pulses.
- Undefined: no watchdog logic, err tied to 0, and the block waits indefinitely.

Test Plan:
- addr=0x1000, len=4, waitrequest=0, readdatavalid 2 cycles after each read, out_ready=1 -> addresses 0x1000/0x1004/0x1008/0x100C; out_data in order; cmd_done 1 pulse; busy low in that cycle.
- len=8, waitrequest high for 3 cycles on the second read -> avm_address=0x1004 and avm_read held across the stall; exactly 8 reads accepted.
- len=10, out_ready=0 -> exactly MAX_OUTSTANDING(4) reads issued, then avm_read=0; raising out_ready resumes; all 10 words delivered; no overflow.
- len=0 -> no avm_read; cmd_done pulses 2 cycles after cmd_start; second cmd_start while busy on a len=3 run -> ignored, only 3 reads.
- addr=0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- reset asserted after 2 accepted reads, then a late readdatavalid -> outputs at reset values, no FIFO push, no cmd_done; with AVM_TIMEOUT_EN, a slave that never returns data -> err=1 after 65535 cycles, then cmd_done.
